// File: rtl/keccak_pkg.sv
// ============================================================================
//  Module   : keccak_pkg
//  Purpose  : Shared constants, FSM encoding and lane helpers for the
//             iterative Keccak-f[1600] sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package keccak_pkg;

  localparam int STATE_W    = 1600;
  localparam int LANE_W     = 64;
  localparam int NUM_ROUNDS = 24;
  localparam int RN_W       = 8;
  localparam int NUM_LANES  = 25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  // Lane (x,y) occupies bits [64*(x+5y)+63 : 64*(x+5y)] of the state vector.
  function automatic int lane_idx(input int x, input int y);
    return x + 5 * y;
  endfunction

  function automatic int lane_lsb(input int x, input int y);
    return LANE_W * lane_idx(x, y);
  endfunction

  function automatic int lane_msb(input int x, input int y);
    return lane_lsb(x, y) + LANE_W - 1;
  endfunction

  localparam int LANE00_LSB = 0;
  localparam int LANE00_MSB = LANE_W - 1;

endpackage

`default_nettype wire

// File: rtl/keccak_round_counter.sv
// ============================================================================
//  Module   : keccak_round_counter
//  Purpose  : Round index counter 0..NUM_ROUNDS-1 with clear, enable and a
//             terminal-count flag; wraps to 0 when enabled at terminal count.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module keccak_round_counter
  import keccak_pkg::*;
#(
  parameter int NUM_ROUNDS = keccak_pkg::NUM_ROUNDS,
  parameter int RN_W       = keccak_pkg::RN_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [RN_W-1:0] round_o,
  output logic            tc_o
);

  localparam logic [RN_W-1:0] C_LAST = RN_W'(NUM_ROUNDS - 1);
  localparam logic [RN_W-1:0] C_ONE  = RN_W'(1);

  logic [RN_W-1:0] round_q;
  logic [RN_W-1:0] round_d;
  logic            tc;

  assign tc = (round_q == C_LAST);

  // Clear wins over enable so a new permutation always starts from round 0.
  always_comb begin
    round_d = round_q;
    if (clr_i) begin
      round_d = '0;
    end else if (en_i) begin
      if (tc) begin
        round_d = '0;
      end else begin
        round_d = round_q + C_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      round_q <= '0;
    end else begin
      round_q <= round_d;
    end
  end

  assign round_o = round_q;
  assign tc_o    = tc;

endmodule

`default_nettype wire

// File: rtl/keccak_round_ctrl.sv
// ============================================================================
//  Module   : keccak_round_ctrl
//  Purpose  : Iterative Keccak-f[1600] sequencer: holds the state register,
//             drives round numbers to an external round datapath and hands
//             the permuted state downstream through a valid/ack handshake.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module keccak_round_ctrl
  import keccak_pkg::*;
#(
  parameter int STATE_W    = keccak_pkg::STATE_W,
  parameter int NUM_ROUNDS = keccak_pkg::NUM_ROUNDS,
  parameter int RN_W       = keccak_pkg::RN_W
) (
  input  logic               inClk,
  input  logic               inRst,
  input  logic               inStart,
  input  logic [STATE_W-1:0] inData,
  output logic               outReady,
  output logic [RN_W-1:0]    outRoundNumber,
  output logic [STATE_W-1:0] outRoundState,
  input  logic [STATE_W-1:0] inRoundState,
  output logic               outValid,
  output logic [STATE_W-1:0] outData,
  input  logic               inAck
);

  fsm_e               fsm_q;
  fsm_e               fsm_d;
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  logic               cnt_clr;
  logic               cnt_en;
  logic [RN_W-1:0]    round;
  logic               round_tc;

  keccak_round_counter #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .RN_W       (RN_W)
  ) u_round_counter (
    .clk_i   (inClk),
    .rst_i   (inRst),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .round_o (round),
    .tc_o    (round_tc)
  );

  // Data inputs are only selected in the state that consumes them, so X on an
  // unused input never reaches the state register.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (inStart) begin
          state_d = inData;
          cnt_clr = 1'b1;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = inRoundState;
        cnt_en  = 1'b1;
        if (round_tc) begin
          fsm_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (inAck) begin
          fsm_d = ST_IDLE;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
    end
  end

  assign outReady       = (fsm_q == ST_IDLE);
  assign outValid       = (fsm_q == ST_DONE);
  assign outRoundNumber = (fsm_q == ST_RUN)  ? round   : '0;
  assign outData        = (fsm_q == ST_DONE) ? state_q : '0;
  assign outRoundState  = state_q;

endmodule

`default_nettype wire
